io_input_fifo: RTL

Input-side counterpart to the processor's output port block. It samples the 18-bit switch bank and an active-low "enter" pushbutton, debounces the button, and on each accepted press queues the switch word in a small FIFO. The processor reads the queue through a show-ahead read port during its input instruction, with one pop per read strobe. It sits between the board switches/button and the register-file write-source path for the input instruction.

---
 rtl/io_pkg.sv | 6 +
 rtl/io_debouncer.sv | 47 ++++
 rtl/io_input_fifo.sv | 89 ++++++++
 3 files changed

// File: rtl/io_pkg.sv
// rtl/io_pkg.sv - shared IO word/switch widths and default button debounce length
package io_pkg;
  localparam int IO_W             = 32;
  localparam int SW_W             = 18;
  localparam int DEBOUNCE_DEFAULT = 16;
endpackage

// File: rtl/io_debouncer.sv
// rtl/io_debouncer.sv - enter button synchronizer, level debouncer and press pulse
module io_debouncer
  import io_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic clock,
  input  logic reset,
  input  logic i_btn_n,
  output logic o_press
);
  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_btn_db;
  logic [CW-1:0] r_cnt;
  logic          w_differs;
  logic          w_accept;

  assign w_differs = (r_sync2 != r_btn_db);
  // the edge that would take the counter to DEBOUNCE_CYCLES is the accept edge
  assign w_accept  = w_differs && (r_cnt == CNT_LAST);
  assign o_press   = w_accept && !r_sync2;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_sync1  <= 1'b1;
      r_sync2  <= 1'b1;
      r_btn_db <= 1'b1;
      r_cnt    <= '0;
    end else begin
      r_sync1 <= i_btn_n;
      r_sync2 <= r_sync1;
      if (!w_differs) begin
        r_cnt <= '0;
      end else if (w_accept) begin
        r_btn_db <= r_sync2;
        r_cnt    <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_ONE;
      end
    end
  end
endmodule

// File: rtl/io_input_fifo.sv
// rtl/io_input_fifo.sv - switch-word input queue filled by debounced enter presses
module io_input_fifo
  import io_pkg::*;
#(
  parameter int DATA_W          = SW_W,
  parameter int DEPTH           = 4,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [DATA_W-1:0]            sw,
  input  logic                         enter_n,
  input  logic                         rd_en,
  output logic [IO_W-1:0]              rd_data,
  output logic                         empty,
  output logic                         full,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         overflow
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] PTR_ONE   = PW'(1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [CW-1:0] CNT_DEPTH = CW'(DEPTH);

  logic [DATA_W-1:0] r_sw_s1;
  logic [DATA_W-1:0] r_sw_s2;
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PW-1:0]     r_wr_ptr;
  logic [PW-1:0]     r_rd_ptr;
  logic [CW-1:0]     r_count;
  logic              r_overflow;
  logic              w_press;
  logic              w_pop;
  logic              w_push;

  io_debouncer #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_debouncer (
    .clock   (clock),
    .reset   (reset),
    .i_btn_n (enter_n),
    .o_press (w_press)
  );

  assign empty    = (r_count == '0);
  assign full     = (r_count == CNT_DEPTH);
  assign count    = r_count;
  assign overflow = r_overflow;
  assign rd_data  = empty ? '0 : IO_W'(r_mem[r_rd_ptr]);

  assign w_pop  = rd_en && !empty;
  // a pop at the same edge frees the slot, so a full queue can still accept
  assign w_push = w_press && (!full || w_pop);

  always_ff @(posedge clock) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= r_sw_s2;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_sw_s1    <= '0;
      r_sw_s2    <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_sw_s1 <= sw;
      r_sw_s2 <= r_sw_s1;
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + CNT_ONE;
      end else if (w_pop && !w_push) begin
        r_count <= r_count - CNT_ONE;
      end
      if (w_press && !w_push) begin
        r_overflow <= 1'b1;
      end
    end
  end
endmodule
